// File: rtl/axi4_master_arb.sv
// axi4_master_arb: round-robin AXI4 read arbiter with an independent single-beat write path
module axi4_master_arb #(
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int BURST_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_req_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_gnt_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  output logic                     rd_last_o,
  output logic                     rd_err_o,
  input  logic                     wr_req_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [DATA_W/8-1:0]      wr_strb_i,
  output logic                     wr_gnt_o,
  output logic                     wr_done_o,
  output logic                     wr_err_o,
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic [DATA_W/8-1:0]      wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);
  localparam int PW = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
  localparam int SW = DATA_W / 8;
  localparam logic [2:0] SIZE = 3'($clog2(SW));
  localparam logic [8:0] LAST_CNT = 9'(BURST_LEN - 1);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  r_state_t r_state_q, r_state_d;
  w_state_t w_state_q, w_state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick;
  logic [8:0] cnt_q, cnt_d;
  logic [NUM_RD-1:0] rd_gnt_q, rd_gnt_d, rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic arvalid_q, arvalid_d, rd_last_q, rd_last_d, rd_err_q, rd_err_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic wr_gnt_q, wr_gnt_d, wr_done_q, wr_done_d, wr_err_q, wr_err_d;
  logic beat;

  assign beat = rvalid && r_state_q == R_DATA && rid == ID_W'(owner_q);

  // round-robin pick: the requester at the smallest offset from the pointer wins
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_RD - 1; k >= 0; k--)
      if (rd_req_i[(int'(ptr_q) + k) % NUM_RD]) pick = PW'((int'(ptr_q) + k) % NUM_RD);
  end

  // read FSM: grant, AR handshake, then register each beat belonging to the owner
  always_comb begin
    r_state_d  = r_state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rd_gnt_d   = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    rd_last_d  = 1'b0;
    rd_err_d   = 1'b0;
    case (r_state_q)
      R_IDLE: if (|rd_req_i) begin
        r_state_d = R_ADDR;
        owner_d   = pick;
        ptr_d     = pick == PW'(NUM_RD - 1) ? '0 : pick + 1'b1;
        araddr_d  = rd_addr_i[pick*ADDR_W +: ADDR_W];
        arvalid_d = 1'b1;
        rd_gnt_d  = NUM_RD'(1) << pick;
        cnt_d     = '0;
      end
      R_ADDR: if (arready) begin
        arvalid_d = 1'b0;
        r_state_d = R_DATA;
      end
      default: if (beat) begin
        rd_valid_d = NUM_RD'(1) << owner_q;
        rd_data_d  = rdata;
        rd_last_d  = rlast;
        rd_err_d   = rresp != 2'b00 || rlast != (cnt_q == LAST_CNT);
        cnt_d      = cnt_q + 1'b1;
        r_state_d  = rlast ? R_IDLE : R_DATA;
      end
    endcase
  end

  // write FSM: capture, independent AW/W handshakes, then wait for B
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wr_gnt_d  = 1'b0;
    wr_done_d = 1'b0;
    wr_err_d  = 1'b0;
    case (w_state_q)
      W_IDLE: if (wr_req_i) begin
        w_state_d = W_SEND;
        awaddr_d  = wr_addr_i;
        wdata_d   = wr_data_i;
        wstrb_d   = wr_strb_i;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        wr_gnt_d  = 1'b1;
      end
      W_SEND: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        w_state_d = !awvalid_d && !wvalid_d ? W_RESP : W_SEND;
      end
      default: if (bvalid) begin
        wr_done_d = 1'b1;
        wr_err_d  = bresp != 2'b00;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // read path registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q  <= R_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rd_gnt_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // write path registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_gnt_q  <= wr_gnt_d;
      wr_done_q <= wr_done_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rd_gnt_o   = rd_gnt_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_err_o   = rd_err_q;
  assign arid       = ID_W'(owner_q);
  assign araddr     = araddr_q;
  assign arlen      = 8'(BURST_LEN - 1);
  assign arsize     = SIZE;
  assign arburst    = 2'b01;
  assign arvalid    = arvalid_q;
  assign rready     = r_state_q == R_DATA;
  assign awid       = awvalid_q ? ID_W'(NUM_RD) : '0;
  assign awaddr     = awaddr_q;
  assign awlen      = '0;
  assign awsize     = SIZE;
  assign awburst    = 2'b01;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = wvalid_q;
  assign wvalid     = wvalid_q;
  assign bready     = w_state_q == W_RESP;
  assign wr_gnt_o   = wr_gnt_q;
  assign wr_done_o  = wr_done_q;
  assign wr_err_o   = wr_err_q;
endmodule

// File: doc/axi4_master_arb.md
Name: axi4_master_arb

Overview:
- Next-generation AXI4 master bridge between the core's memory requesters (IFU, LSU, and later cache refill) and one AXI4 bus.
- Arbitrates NUM_RD read requesters round-robin onto one AR/R channel and runs full valid/ready handshakes.
- Supports BURST_LEN-beat INCR read bursts for line fills and single-beat masked writes with B-response tracking.
- One outstanding read and one outstanding write at a time; the read and write paths run independently.

Parameters:
- NUM_RD, 2, number of read requesters (index 0 = IFU, 1 = LSU).
- ADDR_W, 32, address width.
- DATA_W, 64, data width; AXI size = log2(DATA_W/8).
- ID_W, 4, AXI ID width; read ID = requester index, write ID = NUM_RD.
- BURST_LEN, 1, beats per read (1..256); arlen = BURST_LEN-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rd_req_i  in  NUM_RD  read request per requester; held until rd_gnt_o
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses, slot i at [i*ADDR_W +: ADDR_W]
- rd_gnt_o  out  NUM_RD  one-hot pulse; request captured this cycle
- rd_data_o  out  DATA_W  read beat data
- rd_valid_o  out  NUM_RD  one-hot beat valid to the owning requester
- rd_last_o  out  1  final beat of the burst
- rd_err_o  out  1  rresp != OKAY on this beat
- wr_req_i  in  1  write request; held until wr_gnt_o
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- wr_strb_i  in  DATA_W/8  byte strobes
- wr_gnt_o  out  1  write captured (pulse)
- wr_done_o  out  1  B response received (pulse)
- wr_err_o  out  1  bresp != OKAY, valid with wr_done_o
- AXI AW: awid, awaddr, awlen, awsize, awburst, awvalid out; awready in
- AXI W: wdata, wstrb, wlast, wvalid out; wready in
- AXI B: bid, bresp, bvalid in; bready out
- AXI AR: arid, araddr, arlen, arsize, arburst, arvalid out; arready in
- AXI R: rid, rdata, rresp, rlast, rvalid in; rready out

Behaviour:
- Reset (rst=0, async): all valids, readies, grants, done/err pulses = 0; address/data/id outputs = 0; both FSMs in IDLE; round-robin pointer = 0.
- Constant outputs: arsize/awsize = log2(DATA_W/8); arburst/awburst = INCR (2'b01); awlen = 0; wlast = 1 whenever wvalid = 1.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any rd_req_i is set, grant the first requester at or after the pointer (wrapping). Pulse rd_gnt_o[i], latch araddr/arid = i, assert arvalid, go to R_ADDR. The pointer moves to i+1 mod NUM_RD.
  - R_ADDR: hold arvalid/araddr/arid stable until arvalid & arready, then drop arvalid and go to R_DATA.
  - R_DATA: rready = 1. Each rvalid beat is registered and presented 1 cycle later as rd_data_o with rd_valid_o[owner], rd_err_o = (rresp != 0), and rd_last_o = rlast.
  - On the rlast beat, return to R_IDLE. The next grant is possible the cycle after the last beat is presented.
  - rid != owner is ignored (no beat output). A beat counter flags rd_err_o on the final beat if rlast arrives early or late relative to BURST_LEN.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: on wr_req_i, pulse wr_gnt_o; latch addr/data/strb; assert awvalid and wvalid together; awid = NUM_RD; go to W_SEND.
  - W_SEND: AW and W handshakes complete independently, in either order or the same cycle. Each valid drops on its own handshake. When both are done, go to W_RESP with bready = 1.
  - W_RESP: on bvalid & bready, pulse wr_done_o and wr_err_o = (bresp != 0) the next cycle; drop bready; return to W_IDLE.
- Read and write may be in flight simultaneously. No ordering is enforced between them; the LSU must not read an address with a pending write.
- Simultaneous read requests: only one grant per cycle, in round-robin order. Held requests are never starved; the worst-case wait is NUM_RD-1 transactions.
- Reset asserted mid-transaction aborts everything immediately. Outputs return to reset values; no completion pulse is issued.

Test Plan:
- Single IFU read, BURST_LEN=1, addr 0x8000_0000, arready delayed 3 cycles -> arvalid held 4 cycles with stable addr and arid=0; one rd_valid_o=2'b01 with rd_last_o=1 carrying the slave data.
- IFU and LSU both request in the same cycle, pointer=0 -> IFU granted first, LSU granted after IFU's last beat, next contest grants IFU again (alternation verified over 8 transactions).
- BURST_LEN=4 read from 0x8000_0100 -> arlen=3; 4 beats in order with rd_last_o only on the 4th; a slave rvalid gap of 2 cycles mid-burst is tolerated.
- Write 0xDEAD_BEEF_0000_1234, strb 0x0F, wready before awready -> wvalid drops first, awvalid later; wr_done_o pulses once after bvalid; bresp=SLVERR gives wr_err_o=1.
- Concurrent write and LSU read -> both complete and neither channel stalls the other.
- rst deasserted-asserted during R_DATA on beat 2 of 4 -> all outputs return to 0 immediately; after release, a new request is granted normally.
